emaxi_w_sequencer: RTL

Write-data and write-response stage of the emaxi AXI master. It sits directly downstream of the AW update logic.
- Every accepted AW handshake (awvalid && awready) is captured as {awid, awlen} into a small command FIFO.
- Each command is expanded into exactly awlen+1 W beats, with wid/wlast generated.
- Outstanding transactions are tracked until their B response arrives.
- It provides the back-pressure (aw_room) that gates new AW issue.

---
 rtl/emaxi_w_sequencer_pkg.sv | 29 ++
 rtl/emaxi_w_sequencer_if.sv | 60 ++++++
 rtl/emaxi_cmd_fifo.sv | 61 ++++++
 rtl/emaxi_w_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/emaxi_w_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : emaxi_pkg
// Brief    : Shared AXI constants, command record and W-FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package emaxi_pkg;

    localparam int AXI_ID_W   = 12;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_LEN_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_ID_W-1:0]  id;
        logic [AXI_LEN_W-1:0] len;
    } aw_cmd_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } w_state_t;

endpackage
`default_nettype wire

// File: rtl/emaxi_w_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : emaxi_w_sequencer_if
// Brief    : AW capture, source data, W and B channel bundle of the W stage.
// Revision : 1.0 - initial release
// ============================================================================
interface emaxi_w_sequencer_if
    import emaxi_pkg::*;
#(
    parameter int ID_W   = 12,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
);
    logic                 aw_fire;
    logic [ID_W-1:0]      aw_id;
    logic [AXI_LEN_W-1:0] aw_len;
    logic                 aw_room;

    logic [DATA_W-1:0]    src_data;
    logic [STRB_W-1:0]    src_strb;
    logic                 src_valid;
    logic                 src_ready;

    logic [ID_W-1:0]      m_axi_wid;
    logic [DATA_W-1:0]    m_axi_wdata;
    logic [STRB_W-1:0]    m_axi_wstrb;
    logic                 m_axi_wlast;
    logic                 m_axi_wvalid;
    logic                 m_axi_wready;

    logic [ID_W-1:0]      m_axi_bid;
    logic [1:0]           m_axi_bresp;
    logic                 m_axi_bvalid;
    logic                 m_axi_bready;

    logic                 tx_wactive;
    logic                 tx_bwait;
    logic                 err_ovf;
    logic                 err_bresp;

    modport master (
        input  aw_fire, aw_id, aw_len,
        input  src_data, src_strb, src_valid,
        input  m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output aw_room, src_ready,
        output m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        output m_axi_bready, tx_wactive, tx_bwait, err_ovf, err_bresp
    );

    modport slave (
        output aw_fire, aw_id, aw_len,
        output src_data, src_strb, src_valid,
        output m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  aw_room, src_ready,
        input  m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
        input  m_axi_bready, tx_wactive, tx_bwait, err_ovf, err_bresp
    );

endinterface
`default_nettype wire

// File: rtl/emaxi_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : emaxi_cmd_fifo
// Brief    : Synchronous AW command FIFO; push and pop may coincide.
// Revision : 1.0 - initial release
// ============================================================================
module emaxi_cmd_fifo
    import emaxi_pkg::*;
#(
    parameter int WIDTH = AXI_ID_W + AXI_LEN_W,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] push_data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/emaxi_w_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : emaxi_w_sequencer
// Brief    : Expands accepted AW commands into W bursts and tracks B responses.
// Revision : 1.0 - initial release
// ============================================================================
module emaxi_w_sequencer
    import emaxi_pkg::*;
#(
    parameter int ID_W      = 12,
    parameter int DATA_W    = 64,
    parameter int STRB_W    = DATA_W / 8,
    parameter int CMD_DEPTH = 4,
    parameter int MAX_OUT   = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    emaxi_w_sequencer_if.master bus
);
    localparam int CMD_W = ID_W + AXI_LEN_W;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    w_state_t             state_q, state_d;
    logic [ID_W-1:0]      cur_id_q, cur_id_d;
    logic [AXI_LEN_W-1:0] beats_left_q, beats_left_d;
    logic [OUT_W-1:0]     outstanding_q;
    logic                 err_ovf_q;
    logic                 err_bresp_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [CMD_W-1:0]     fifo_head;

    logic                 aw_room;
    logic                 push_ok;
    logic                 bready;
    logic                 b_fire;
    logic                 active;
    logic                 beat_fire;
    logic                 last_beat;
    logic                 unused_b;

    // Room depends only on registered counts so aw_fire never loops back into it.
    assign aw_room   = !fifo_full && (outstanding_q < OUT_W'(MAX_OUT));
    assign push_ok   = bus.aw_fire && aw_room;
    assign bready    = (outstanding_q != '0);
    assign b_fire    = bus.m_axi_bvalid && bready;
    assign active    = (state_q == BURST);
    assign last_beat = (beats_left_q == '0);
    assign beat_fire = active && bus.src_valid && bus.m_axi_wready;
    assign unused_b  = ^{bus.m_axi_bid, bus.m_axi_bresp[0]};

    emaxi_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_ok),
        .push_data_i ({bus.aw_id, bus.aw_len}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cur_id_d     = cur_id_q;
        beats_left_d = beats_left_q;
        fifo_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    cur_id_d     = fifo_head[CMD_W-1:AXI_LEN_W];
                    beats_left_d = fifo_head[AXI_LEN_W-1:0];
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (beat_fire) begin
                    if (!last_beat) begin
                        beats_left_d = beats_left_q - 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next burst without a bubble.
                        fifo_pop     = 1'b1;
                        cur_id_d     = fifo_head[CMD_W-1:AXI_LEN_W];
                        beats_left_d = fifo_head[AXI_LEN_W-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_id_q     <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_id_q     <= cur_id_d;
            beats_left_q <= beats_left_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            err_ovf_q     <= 1'b0;
            err_bresp_q   <= 1'b0;
        end else begin
            if (push_ok && !b_fire) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (!push_ok && b_fire) begin
                outstanding_q <= outstanding_q - 1'b1;
            end
            if (bus.aw_fire && !aw_room) begin
                err_ovf_q <= 1'b1;
            end
            if (b_fire && bus.m_axi_bresp[1]) begin
                err_bresp_q <= 1'b1;
            end
        end
    end

    assign bus.aw_room      = aw_room;
    assign bus.src_ready    = active && bus.m_axi_wready;
    assign bus.m_axi_wvalid = active && bus.src_valid;
    assign bus.m_axi_wlast  = active && last_beat;
    assign bus.m_axi_wid    = active ? cur_id_q : ID_W'(0);
    assign bus.m_axi_wdata  = active ? bus.src_data : DATA_W'(0);
    assign bus.m_axi_wstrb  = active ? bus.src_strb : STRB_W'(0);
    assign bus.m_axi_bready = bready;
    assign bus.tx_wactive   = active;
    assign bus.tx_bwait     = bready;
    assign bus.err_ovf      = err_ovf_q;
    assign bus.err_bresp    = err_bresp_q;

endmodule
`default_nettype wire
